// File: rtl/sar_search_signed_pkg.sv
// Shared types and constant helpers for the signed successive-approximation search.
package sar_search_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} sar_state_t;

  // One-hot MSB of an n-bit word; XOR with it maps offset-binary <-> two's complement.
  function automatic logic [63:0] msb_flip(input int n);
    msb_flip = 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/sar_search_signed_if.sv
// Probe/answer handshake between the searcher and a signed less-than oracle.
interface sar_search_signed_if #(parameter int N = 32);
  logic                probe_valid;
  logic signed [N-1:0] probe;
  logic                resp_valid;
  logic                resp_lt;

  modport master (output probe_valid, probe, input resp_valid, resp_lt);
  modport slave  (input probe_valid, probe, output resp_valid, resp_lt);
endinterface

// File: rtl/sar_search_signed.sv
// MSB-first successive-approximation search recovering a signed N-bit target
// from an external "target < probe" oracle, one bit per handshake.
module sar_search_signed
  import sar_search_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] result,
  sar_search_signed_if.master ora
);

  localparam logic [N-1:0] MSB = N'(msb_flip(N));

  sar_state_t   state_q, state_d;
  logic [N-1:0] acc_q, acc_d, mask_q, mask_d;
  logic [N-1:0] probe_q, probe_d, result_q, result_d;
  logic [N-1:0] acc_nx;
  logic         busy_q, busy_d, pv_q, pv_d, done_q, done_d;

  // Search runs in offset binary so the signed order matches the unsigned bit trial.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    probe_d  = probe_q;
    result_d = result_q;
    busy_d   = busy_q;
    pv_d     = pv_q;
    done_d   = 1'b0;
    acc_nx   = ora.resp_lt ? acc_q : (acc_q | mask_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PROBE;
          acc_d   = '0;
          mask_d  = MSB;
          probe_d = '0;  // (0 | MSB) ^ MSB
          busy_d  = 1'b1;
          pv_d    = 1'b1;
        end
      end
      S_PROBE: begin
        if (ora.resp_valid) begin
          acc_d  = acc_nx;
          mask_d = mask_q >> 1;
          if (mask_q[0]) begin
            result_d = acc_nx ^ MSB;
            state_d  = S_DONE;
            pv_d     = 1'b0;
            probe_d  = '0;
            done_d   = 1'b1;
          end else begin
            probe_d = (acc_nx | (mask_q >> 1)) ^ MSB;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      pv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      pv_q     <= pv_d;
      done_q   <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign ora.probe_valid = pv_q;
  assign ora.probe       = probe_q;

endmodule

// File: tb/tb_sar_search_signed.sv
// Scoreboarded bench: behavioural signed less-than oracle with programmable answer delay.
module tb_sar_search_signed;
  localparam int N = 8;

  logic                clk = 1'b0;
  logic                rst, start, busy, done;
  logic signed [N-1:0] result;
  logic signed [N-1:0] target;
  int                  delay;
  logic                idle_rv;
  int                  wait_cnt = 0;
  int                  hs_cnt = 0;
  logic signed [N-1:0] probe_log[$];
  logic [N-1:0]        sb[$];
  int                  checks = 0, failures = 0;
  bit                  chk_stable = 1'b0;
  logic                prev_pv = 1'b0, prev_rv = 1'b0, prev_done = 1'b0;
  logic signed [N-1:0] prev_probe = '0;

  always #5 clk = ~clk;

  sar_search_signed_if #(.N(N)) ora();

  sar_search_signed #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .done(done), .result(result), .ora(ora)
  );

  assign ora.resp_lt    = target < ora.probe;
  assign ora.resp_valid = (ora.probe_valid && wait_cnt >= delay) || idle_rv;

  always @(posedge clk) begin
    if (!ora.probe_valid || ora.resp_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (!rst && ora.probe_valid && ora.resp_valid) begin
      hs_cnt <= hs_cnt + 1;
      probe_log.push_back(ora.probe);
    end
  end

  // Scoreboard, done-width and probe-hold monitor.
  always @(negedge clk) begin
    logic [N-1:0] exp_r;
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected result=%0d expected no done", result);
      end else begin
        exp_r = sb.pop_front();
        if (result !== exp_r) begin
          failures++;
          $display("FAIL sb_result got=%h exp=%h", result, exp_r);
        end
      end
    end
    if (prev_done) begin
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_width done=%b exp=0", done);
      end
    end
    if (chk_stable && prev_pv && !prev_rv && ora.probe_valid) begin
      checks++;
      if (ora.probe !== prev_probe) begin
        failures++;
        $display("FAIL probe_hold got=%0d exp=%0d", ora.probe, prev_probe);
      end
    end
    prev_done  <= done;
    prev_pv    <= ora.probe_valid;
    prev_rv    <= ora.resp_valid;
    prev_probe <= ora.probe;
  end

  task automatic run_search(input logic signed [N-1:0] tgt, input int dly, input bit spam,
                            output int cyc, output int hs);
    int hs0;
    @(negedge clk);
    target = tgt;
    delay  = dly;
    hs0    = hs_cnt;
    start  = 1'b1;
    sb.push_back(tgt);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (!spam) start = 1'b0;
      if (cyc >= 400) begin
        checks++; failures++;
        $display("FAIL search_timeout cycles=%0d limit=400", cyc);
        break;
      end
    end
    start = 1'b0;
    hs = hs_cnt - hs0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; idle_rv = 1'b0; target = '0; delay = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, ora.probe_valid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, ora.probe_valid});
    end
    checks++;
    if (ora.probe !== 0 || result !== 0) begin
      failures++; $display("FAIL reset_data probe=%0d result=%0d exp=0", ora.probe, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_min();
    int cyc, hs, base;
    logic signed [N-1:0] e;
    base = probe_log.size();
    run_search(-8'sd128, 0, 1'b0, cyc, hs);
    checks++;
    if (cyc != 9) begin failures++; $display("FAIL min_latency got=%0d exp=9", cyc); end
    checks++;
    if (hs != 8) begin failures++; $display("FAIL min_handshakes got=%0d exp=8", hs); end
    checks++;
    if (result !== 8'sh80) begin failures++; $display("FAIL min_result got=%h exp=80", result); end
    for (int k = 0; k < 8; k++) begin
      e = N'(-128 + (128 >> k));
      checks++;
      if (probe_log[base+k] !== e) begin
        failures++; $display("FAIL min_probe%0d got=%0d exp=%0d", k, probe_log[base+k], e);
      end
    end
  endtask

  task automatic test_extremes();
    int cyc, hs;
    logic signed [N-1:0] tv [3] = '{8'sh7F, 8'shFF, 8'sh00};
    for (int i = 0; i < 3; i++) begin
      run_search(tv[i], 0, 1'b0, cyc, hs);
      checks++;
      if (result !== tv[i] || hs != 8) begin
        failures++; $display("FAIL extreme result=%h hs=%0d exp=%h hs=8", result, hs, tv[i]);
      end
    end
  endtask

  task automatic test_wait();
    int cyc, hs;
    chk_stable = 1'b1;
    run_search(8'sd37, 3, 1'b0, cyc, hs);
    chk_stable = 1'b0;
    checks++;
    if (cyc != 33) begin failures++; $display("FAIL wait_latency got=%0d exp=33", cyc); end
    checks++;
    if (result !== 8'sd37 || hs != 8) begin
      failures++; $display("FAIL wait_result got=%0d hs=%0d exp=37 hs=8", result, hs);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, hs, pcyc;
    @(negedge clk);
    target = 8'sd37; delay = 0; start = 1'b1;
    pcyc = 0;
    while (pcyc < 4) begin
      @(negedge clk);
      start = 1'b0;
      if (ora.probe_valid) pcyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, ora.probe_valid} !== 3'b000 || ora.probe !== 0 || result !== 0) begin
      failures++;
      $display("FAIL abort_outputs busy=%b done=%b pv=%b probe=%0d result=%0d exp all 0",
               busy, done, ora.probe_valid, ora.probe, result);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL abort_quiet done=%b busy=%b exp=0", done, busy);
      end
    end
    run_search(-8'sd5, 0, 1'b0, cyc, hs);
    checks++;
    if (result !== 8'shFB) begin failures++; $display("FAIL abort_restart got=%h exp=FB", result); end
  endtask

  task automatic test_start_spam();
    int cyc, hs;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_rv = ~idle_rv;
      checks++;
      if (busy !== 1'b0 || ora.probe_valid !== 1'b0) begin
        failures++; $display("FAIL idle_resp busy=%b pv=%b exp=0", busy, ora.probe_valid);
      end
    end
    idle_rv = 1'b0;
    run_search(-8'sd77, 0, 1'b1, cyc, hs);
    checks++;
    if (hs != 8 || cyc != 9) begin
      failures++; $display("FAIL spam_hs hs=%0d cyc=%0d exp hs=8 cyc=9", hs, cyc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL spam_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_sweep();
    int cyc, hs, j;
    logic signed [N-1:0] tv [256];
    logic signed [N-1:0] tmp;
    for (int i = 0; i < 256; i++) tv[i] = N'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = tv[i]; tv[i] = tv[j]; tv[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      run_search(tv[i], int'($urandom_range(0, 1)), 1'b0, cyc, hs);
      checks++;
      if (hs != 8) begin failures++; $display("FAIL sweep_hs t=%0d got=%0d exp=8", tv[i], hs); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL sweep_idle t=%0d busy=%b exp=0", tv[i], busy); end
    end
  endtask

  initial begin
    test_reset();
    test_min();
    test_extremes();
    test_wait();
    test_reset_abort();
    test_start_spam();
    test_sweep();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
